// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared constants and types for the RV32/RV64 decode stage:
//   - major opcode values (instr[6:0])
//   - bit positions inside the one-hot format vector {J,U,B,S,I,R}
//   - funct7 values that qualify the OP (register-register) class
//   - the packed bundle of decoded fields held in the stage registers
// ---------------------------------------------------------------------------
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int FMT_W = 6;
  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } dec_fields_t;

endpackage

// File: rtl/decode_fields.sv
// ---------------------------------------------------------------------------
// decode_fields
// Purely combinational RISC-V instruction decoder.
//   i_instr   : raw 32-bit instruction word
//   o_opcode, o_funct3, o_funct7, o_rs1, o_rs2, o_rd : raw field slices
//   o_imm     : immediate sign-extended to XLEN (0 for R-type and illegal)
//   o_fmt     : one-hot {J,U,B,S,I,R}, all-zero for an illegal encoding
//   o_illegal : encoding is unsupported for this XLEN / SUPPORT_M setting
// ---------------------------------------------------------------------------
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic [31:0]      i_instr,
  output logic [6:0]       o_opcode,
  output logic [2:0]       o_funct3,
  output logic [6:0]       o_funct7,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [XLEN-1:0]  o_imm,
  output logic [FMT_W-1:0] o_fmt,
  output logic             o_illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [20:0] w_imm_j;
  logic              w_sh_zero;
  logic              w_sh_alt;
  logic [FMT_W-1:0]  w_fmt;
  logic              w_ill;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];

  assign w_imm_i = i_instr[31:20];
  assign w_imm_s = {i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Shift-immediate upper field: RV64 has a 6-bit shamt, so only
  // instr[31:26] qualifies the shift; RV32 uses the full funct7.
  generate
    if (RV64) begin : g_sh64
      assign w_sh_zero = (i_instr[31:26] == F7_BASE[6:1]);
      assign w_sh_alt  = (i_instr[31:26] == F7_ALT[6:1]);
    end else begin : g_sh32
      assign w_sh_zero = (w_f7 == F7_BASE);
      assign w_sh_alt  = (w_f7 == F7_ALT);
    end
  endgenerate

  always_comb begin
    w_fmt = '0;
    w_ill = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_fmt[FMT_R] = 1'b1;
        w_ill = !((w_f7 == F7_BASE) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                  ((w_f7 == F7_MULDIV) && SUPPORT_M));
      end
      OPC_OPIMM: begin
        w_fmt[FMT_I] = 1'b1;
        if (w_f3 == 3'b001)      w_ill = !w_sh_zero;
        else if (w_f3 == 3'b101) w_ill = !(w_sh_zero || w_sh_alt);
      end
      OPC_LOAD: begin
        w_fmt[FMT_I] = 1'b1;
        w_ill = RV64 ? (w_f3 == 3'b111)
                     : ((w_f3 == 3'b011) || (w_f3 >= 3'b110));
      end
      OPC_JALR: begin
        w_fmt[FMT_I] = 1'b1;
        w_ill = (w_f3 != 3'b000);
      end
      OPC_SYSTEM: w_fmt[FMT_I] = 1'b1;
      OPC_STORE: begin
        w_fmt[FMT_S] = 1'b1;
        w_ill = RV64 ? (w_f3 >= 3'b100) : (w_f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        w_fmt[FMT_B] = 1'b1;
        w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: w_fmt[FMT_U] = 1'b1;
      OPC_JAL:            w_fmt[FMT_J] = 1'b1;
      default:            w_ill = 1'b1;
    endcase
    // Compressed (16-bit) encodings are not handled by this stage.
    if (i_instr[1:0] != 2'b11) w_ill = 1'b1;
  end

  always_comb begin
    o_imm = '0;
    if (!w_ill) begin
      if (w_fmt[FMT_I])      o_imm = XLEN'(w_imm_i);
      else if (w_fmt[FMT_S]) o_imm = XLEN'(w_imm_s);
      else if (w_fmt[FMT_B]) o_imm = XLEN'(w_imm_b);
      else if (w_fmt[FMT_U]) o_imm = XLEN'(w_imm_u);
      else if (w_fmt[FMT_J]) o_imm = XLEN'(w_imm_j);
    end
  end

  assign o_opcode  = w_opc;
  assign o_funct3  = w_f3;
  assign o_funct7  = w_f7;
  assign o_rs1     = i_instr[19:15];
  assign o_rs2     = i_instr[24:20];
  assign o_rd      = i_instr[11:7];
  assign o_fmt     = w_ill ? '0 : w_fmt;
  assign o_illegal = w_ill;

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered decode stage between fetch and register-read/execute.
//   clk, rst_n            : clock, asynchronous active-low reset (deassertion
//                           is expected to be synchronised by the SoC top)
//   flush                 : drop every held instruction
//   in_valid/in_ready     : fetch handshake (in_ready is a flop output)
//   in_instr, in_pc       : instruction word and its address
//   out_valid/out_ready   : downstream handshake
//   out_opcode..out_rd    : raw instruction fields
//   out_imm, out_fmt      : sign-extended immediate, one-hot {J,U,B,S,I,R}
//   out_illegal, out_pc   : illegal-encoding flag and instruction address
// A main register drives the outputs; a single skid register absorbs the
// one instruction that may arrive while the main register is stalled, which
// lets in_ready be registered without losing throughput.
// ---------------------------------------------------------------------------
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b1,
  parameter int PC_W      = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_fmt,
  output logic             out_illegal,
  output logic [PC_W-1:0]  out_pc
);

  dec_fields_t      w_dec;
  logic [XLEN-1:0]  w_imm;
  logic             w_accept;
  logic             w_main_free;

  dec_fields_t      r_main_dec;
  logic [XLEN-1:0]  r_main_imm;
  logic [PC_W-1:0]  r_main_pc;
  logic             r_main_vld;
  dec_fields_t      r_skid_dec;
  logic [XLEN-1:0]  r_skid_imm;
  logic [PC_W-1:0]  r_skid_pc;
  logic             r_skid_vld;
  logic             r_in_ready;

  decode_fields #(
    .XLEN      (XLEN),
    .SUPPORT_M (SUPPORT_M)
  ) u_fields (
    .i_instr   (in_instr),
    .o_opcode  (w_dec.opcode),
    .o_funct3  (w_dec.funct3),
    .o_funct7  (w_dec.funct7),
    .o_rs1     (w_dec.rs1),
    .o_rs2     (w_dec.rs2),
    .o_rd      (w_dec.rd),
    .o_imm     (w_imm),
    .o_fmt     (w_dec.fmt),
    .o_illegal (w_dec.illegal)
  );

  assign w_accept    = in_valid & r_in_ready;
  // Main can take a new entry when empty or when it hands off this cycle.
  assign w_main_free = !r_main_vld || out_ready;

  // Control: occupancy of main/skid and the registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_main_free) begin
      // Skid is older than anything arriving now, so it wins the refill;
      // r_in_ready is low whenever skid is full, so no accept collides.
      if (r_skid_vld) begin
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
        r_in_ready <= 1'b1;
      end else begin
        r_main_vld <= w_accept;
      end
    end else if (w_accept) begin
      r_skid_vld <= 1'b1;
      r_in_ready <= 1'b0;
    end
  end

  // Data: loads track the control decisions above; a flush only needs to
  // clear the valids, so stale data here is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_dec <= '0;
      r_main_imm <= '0;
      r_main_pc  <= '0;
      r_skid_dec <= '0;
      r_skid_imm <= '0;
      r_skid_pc  <= '0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        r_main_dec <= r_skid_dec;
        r_main_imm <= r_skid_imm;
        r_main_pc  <= r_skid_pc;
      end else if (w_accept) begin
        r_main_dec <= w_dec;
        r_main_imm <= w_imm;
        r_main_pc  <= in_pc;
      end
    end else if (w_accept) begin
      r_skid_dec <= w_dec;
      r_skid_imm <= w_imm;
      r_skid_pc  <= in_pc;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_vld;
  assign out_opcode  = r_main_dec.opcode;
  assign out_funct3  = r_main_dec.funct3;
  assign out_funct7  = r_main_dec.funct7;
  assign out_rs1     = r_main_dec.rs1;
  assign out_rs2     = r_main_dec.rs2;
  assign out_rd      = r_main_dec.rd;
  assign out_imm     = r_main_imm;
  assign out_fmt     = r_main_dec.fmt;
  assign out_illegal = r_main_dec.illegal;
  assign out_pc      = r_main_pc;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32/RV64 instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Takes a fetched instruction and PC.
- Produces the split fields, the sign-extended immediate, a one-hot format class and an illegal-instruction flag, one cycle later.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Sits between the fetch stage and the register-read/execute stage; supports pipeline flush on branch/trap.

Parameters:
XLEN, 32, datapath width (32 or 64); immediate and PC widths
SUPPORT_M, 1, 1 = OP-class funct7=0000001 (M extension) is legal; 0 = flagged illegal
PC_W, XLEN, width of the PC carried alongside the instruction

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  discard all held instructions
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept (registered)
in_instr  in  32  raw instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded instruction available
out_ready  in  1  downstream accepts
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_rd  out  5  instr[11:7]
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  6  one-hot {J,U,B,S,I,R}; all-zero when illegal
out_illegal  out  1  unsupported/invalid encoding
out_pc  out  PC_W  PC of the decoded instruction

Behaviour:
- Reset (async assert, sync deassert at the top level): out_valid=0, in_ready=1, skid empty; all data outputs 0.
- Decode is combinational on in_instr and captured on accept (in_valid & in_ready). Latency: accept at edge N gives out_valid=1 after edge N.
- Storage is a main register feeding the outputs, plus one skid register.
  - in_ready = !skid_valid, registered.
  - Accept while main is empty, or main drains the same cycle (out_ready=1): load main.
  - Accept while main is valid and out_ready=0: load skid; in_ready drops next cycle.
  - Main drains (out_valid & out_ready) while skid is valid: skid moves to main, skid empties, in_ready rises next cycle.
  - Order is always preserved; no instruction is dropped or duplicated without flush.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Flush has priority over everything:
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An accept in the flush cycle is discarded.
- Immediate formats, each sign-extended from its top bit to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R/illegal: imm=0.
- Format classes:
  - R: OP 0110011
  - I: OP-IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011
  - S: STORE 0100011
  - B: BRANCH 1100011
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
- illegal=1 when any of:
  - instr[1:0] != 2'b11
  - opcode outside the list above
  - BRANCH with funct3 010 or 011
  - LOAD funct3 011/110/111 (XLEN=32), or 111 (XLEN=64)
  - STORE funct3 >= 011 (XLEN=32), or >= 100 (XLEN=64)
  - JALR funct3 != 0
  - OP with funct7 outside {0000000, 0100000 (funct3 000/101 only), 0000001 (when SUPPORT_M)}
  - OP-IMM shift (funct3 001/101) with an illegal upper field
- An illegal instruction still flows through with its fields and PC, so downstream can trap.

Decomposition:
- Shared package holds:
  - opcode localparams (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM)
  - FMT_* one-hot bit indices
  - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV)
- One sub-module, decode_fields: combinational instr -> {fields, imm, fmt, illegal}, parametrised by XLEN/SUPPORT_M.
- decode_stage adds the handshake/skid registers and flush.

Test Plan:
- Decode/latency: 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> one cycle later opcode=0x13, rd=1, rs1=2, imm=0xFFFFFFFF, fmt=I, illegal=0.
- S and B immediates: 0x00532423 (sw x5,8(x6)) -> rs1=6, rs2=5, imm=8, fmt=S. Then 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, fmt=B.
- Illegal handling: 0x022081B3 (mul x3,x1,x2) with SUPPORT_M=0 -> illegal=1, fmt=0, rd=3. With SUPPORT_M=1 -> illegal=0, fmt=R. Also 0x00000000 -> illegal=1.
- Backpressure: out_ready=0, in_valid=1 with instrs A,B,C on successive cycles -> A in main, B in skid, in_ready=0, C stalled. Raise out_ready -> A, B, C emitted in order, one per cycle, with no bubbles after the first.
- Flush: main and skid full, flush=1 coincident with in_valid -> next cycle out_valid=0, in_ready=1, the next instruction is accepted normally.
- Reset mid-stream: drop rst_n while out_valid=1 -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
